// File: rtl/i2s_rx_pkg.sv
// ---------------------------------------------------------------------------
// i2s_rx_pkg
// Shared definitions for the I2S receiver: default word/slot geometry,
// receiver state encoding and a helper that sizes the per-slot bit counter.
// ---------------------------------------------------------------------------
package i2s_rx_pkg;

    // Default geometry: 24 data bits carried in a 32-BCLK slot per channel.
    localparam int DATA_W_DEF = 24;
    localparam int SLOT_W_DEF = 32;

    // Receiver framing states.
    //   SYNC_WAIT : no frame alignment yet, waiting for a 1->0 word-select edge
    //   LEFT      : collecting the left-channel slot
    //   RIGHT     : collecting the right-channel slot
    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } rx_state_e;

    // Width of the bit counter that indexes BCLK periods within one slot.
    function automatic int cnt_width(input int slot_w);
        return (slot_w > 1) ? $clog2(slot_w) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(SLOT_W_DEF);

endpackage : i2s_rx_pkg

// File: rtl/i2s_sync.sv
// ---------------------------------------------------------------------------
// i2s_sync
// Three-flop synchronizer for one asynchronous I2S pin, followed by a
// registered output stage. The level output and the rising-edge output are
// registered in the same cycle, so a level taken from one instance lines up
// exactly with the rise strobe taken from another instance fed the same way.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   async_in  in   raw pin (asynchronous to clk)
//   level     out  synchronized level (stage 2, registered)
//   rise      out  one-cycle pulse on a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module i2s_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic stage1_q, stage1_d;
    logic stage2_q, stage2_d;
    logic stage3_q, stage3_d;
    logic level_q,  level_d;
    logic rise_q,   rise_d;

    always_comb begin
        stage1_d = async_in;
        stage2_d = stage1_q;
        stage3_d = stage2_q;
        // Both outputs are derived from stage 2 so that every pin sees the
        // same total delay regardless of whether its level or edge is used.
        level_d  = stage2_q;
        rise_d   = stage2_q & ~stage3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_q <= 1'b0;
            stage2_q <= 1'b0;
            stage3_q <= 1'b0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
            stage3_q <= stage3_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule : i2s_sync

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
// I2S receiver front end. Brings BCLK, LRCLK and SD into the system clock
// domain, frames the serial stream into left/right slots and presents one
// stereo pair per frame with a single-cycle valid strobe. Slot-length
// violations raise a single-cycle error strobe and force a resync on the
// next falling word-select edge.
//
// Parameters
//   DATA_W  bits captured per channel, MSB first (must be <= SLOT_W-1)
//   SLOT_W  BCLK periods per channel slot
//
// Ports
//   clk           in   system clock (>= 4x BCLK)
//   rst_n         in   asynchronous active-low reset
//   i2s_bclk      in   I2S bit clock (asynchronous)
//   i2s_lrclk     in   word select, 0 = left, 1 = right
//   i2s_sd        in   serial data, sampled on BCLK rising edge
//   audio_left    out  last complete left sample
//   audio_right   out  last complete right sample
//   sample_valid  out  one-cycle pulse when both outputs update
//   frame_err     out  one-cycle pulse on slot-length violation
// ---------------------------------------------------------------------------
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SLOT_W = SLOT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i2s_bclk,
    input  logic              i2s_lrclk,
    input  logic              i2s_sd,
    output logic [DATA_W-1:0] audio_left,
    output logic [DATA_W-1:0] audio_right,
    output logic              sample_valid,
    output logic              frame_err
);

    localparam int                CNT_W     = cnt_width(SLOT_W);
    localparam logic [CNT_W-1:0]  DATA_CNT  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SLOT_W - 1);

    // -----------------------------------------------------------------------
    // Pin synchronization: bit 0 = bclk, bit 1 = lrclk, bit 2 = sd.
    // All three go through identical chains so they stay cycle-aligned.
    // -----------------------------------------------------------------------
    logic [2:0] pin_async;
    logic [2:0] pin_level;
    logic [2:0] pin_rise;

    assign pin_async = {i2s_sd, i2s_lrclk, i2s_bclk};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        i2s_sync u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .async_in (pin_async[gi]),
            .level    (pin_level[gi]),
            .rise     (pin_rise[gi])
        );
    end

    logic bclk_rise;
    logic lr_s;
    logic sd_s;

    assign bclk_rise = pin_rise[0];
    assign lr_s      = pin_level[1];
    assign sd_s      = pin_level[2];

    // Only the bclk edge and the lrclk/sd levels are needed.
    logic unused_sync;
    assign unused_sync = ^{pin_level[0], pin_rise[2:1]};

    // -----------------------------------------------------------------------
    // Framing state
    // -----------------------------------------------------------------------
    rx_state_e         state_q,        state_d;
    logic              lr_prev_q,      lr_prev_d;
    logic [CNT_W-1:0]  cnt_q,          cnt_d;
    logic [DATA_W-1:0] shreg_q,        shreg_d;
    logic [DATA_W-1:0] left_hold_q,    left_hold_d;
    logic [DATA_W-1:0] audio_left_q,   audio_left_d;
    logic [DATA_W-1:0] audio_right_q,  audio_right_d;
    logic              sample_valid_q, sample_valid_d;
    logic              frame_err_q,    frame_err_d;

    logic              lr_change;
    logic [DATA_W-1:0] word_next;

    always_comb begin
        state_d        = state_q;
        lr_prev_d      = lr_prev_q;
        cnt_d          = cnt_q;
        shreg_d        = shreg_q;
        left_hold_d    = left_hold_q;
        audio_left_d   = audio_left_q;
        audio_right_d  = audio_right_q;
        sample_valid_d = 1'b0;
        frame_err_d    = 1'b0;

        lr_change = (lr_s != lr_prev_q);
        // Shift register contents including the bit arriving on this rise;
        // on the DATA_W-th data bit this is the completed word.
        word_next = {shreg_q[DATA_W-2:0], sd_s};

        if (bclk_rise) begin
            lr_prev_d = lr_s;

            case (state_q)
                SYNC_WAIT: begin
                    // Data is ignored until a 1->0 word-select edge marks the
                    // start of a left slot.
                    cnt_d = '0;
                    if (lr_change && !lr_s) begin
                        state_d = LEFT;
                    end
                end

                LEFT, RIGHT: begin
                    if (lr_change) begin
                        // The sd bit on a word-select change still belongs to
                        // the slot that is ending, so it is not captured.
                        cnt_d = '0;
                        if (cnt_q < DATA_CNT) begin
                            // Slot ended before a full word: drop it and wait
                            // for the next falling edge (not this one).
                            frame_err_d = 1'b1;
                            state_d     = SYNC_WAIT;
                        end else if (state_q == LEFT) begin
                            state_d = RIGHT;
                        end else begin
                            state_d = LEFT;
                        end
                    end else if (cnt_q == SLOT_LAST) begin
                        // Slot ran past its nominal length.
                        frame_err_d = 1'b1;
                        state_d     = SYNC_WAIT;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q < DATA_CNT) begin
                            shreg_d = word_next;
                        end
                        if (cnt_q == DATA_LAST) begin
                            if (state_q == LEFT) begin
                                left_hold_d = word_next;
                            end else begin
                                audio_left_d   = left_hold_q;
                                audio_right_d  = word_next;
                                sample_valid_d = 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_d = SYNC_WAIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SYNC_WAIT;
            lr_prev_q      <= 1'b0;
            cnt_q          <= '0;
            shreg_q        <= '0;
            left_hold_q    <= '0;
            audio_left_q   <= '0;
            audio_right_q  <= '0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lr_prev_q      <= lr_prev_d;
            cnt_q          <= cnt_d;
            shreg_q        <= shreg_d;
            left_hold_q    <= left_hold_d;
            audio_left_q   <= audio_left_d;
            audio_right_q  <= audio_right_d;
            sample_valid_q <= sample_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign audio_left   = audio_left_q;
    assign audio_right  = audio_right_q;
    assign sample_valid = sample_valid_q;
    assign frame_err    = frame_err_q;

endmodule : i2s_rx

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx
// Self-checking bench for i2s_rx: directed frame table, hand-written reset
// sequences and a randomized slot stream checked against a slot-level model.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

    localparam int DW = 24;
    localparam int SW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i2s_bclk = 1'b0;
    logic          i2s_lrclk = 1'b0;
    logic          i2s_sd = 1'b0;
    logic [DW-1:0] audio_left;
    logic [DW-1:0] audio_right;
    logic          sample_valid;
    logic          frame_err;

    i2s_rx #(.DATA_W(DW), .SLOT_W(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sd       (i2s_sd),
        .audio_left   (audio_left),
        .audio_right  (audio_right),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            err;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            cyc;
    } ev_t;

    typedef struct {
        int            llen;
        int            rlen;
        logic [DW-1:0] lw;
        logic [DW-1:0] rw;
        int            pad;
        int            exp_valid;
        int            exp_err;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
    } row_t;

    typedef struct {
        logic          lr;
        int            len;
        logic [DW-1:0] w;
    } slot_t;

    int   errors = 0;
    int   checks = 0;
    int   cycle_cnt = 0;
    int   viol = 0;
    ev_t  obs_q[$];
    int   rise_cyc[8192];
    int   g_drv = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse monitor: samples 1 time unit after each clock edge.
    initial begin : mon
        bit  prev_pulse;
        ev_t e;
        prev_pulse = 1'b0;
        forever begin
            @(posedge clk);
            cycle_cnt++;
            #1;
            if (sample_valid === 1'b1 && frame_err === 1'b1) viol++;
            if ((sample_valid === 1'b1 || frame_err === 1'b1) && prev_pulse) viol++;
            if (sample_valid === 1'b1) begin
                e.err = 1'b0; e.l = audio_left; e.r = audio_right; e.cyc = cycle_cnt;
                obs_q.push_back(e);
                $display("obs valid L=%06h R=%06h cyc=%0d", audio_left, audio_right, cycle_cnt);
            end
            if (frame_err === 1'b1) begin
                e.err = 1'b1; e.l = '0; e.r = '0; e.cyc = cycle_cnt;
                obs_q.push_back(e);
                $display("obs frame_err cyc=%0d", cycle_cnt);
            end
            prev_pulse = (sample_valid === 1'b1) || (frame_err === 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    // One BCLK period: data/lr change with bclk low, then a rise.
    // Called and returns at posedge+2 alignment.
    task automatic bit_rise(input logic lr, input logic sd);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_sd    = sd;
        repeat (4) @(posedge clk);
        #2;
        i2s_bclk = 1'b1;
        rise_cyc[g_drv] = cycle_cnt + 1;  // first sync flop captures next edge
        g_drv++;
        repeat (4) @(posedge clk);
        #2;
    endtask

    // pad_mode: 0 = zeros, 1 = ones, 2 = random
    task automatic drive_slot(input logic lr, input int len, input logic [DW-1:0] word,
                              input int pad_mode, output int start);
        start = g_drv;
        for (int i = 0; i < len; i++) begin
            logic b;
            if (i == 0)       b = 1'($urandom_range(0, 1));
            else if (i <= DW) b = word[DW-i];
            else if (pad_mode == 2) b = 1'($urandom_range(0, 1));
            else              b = pad_mode[0];
            bit_rise(lr, b);
        end
    endtask

    task automatic count_obs(output int nv, output int ne);
        nv = 0; ne = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].err) ne++;
            else nv++;
        end
    endtask

    row_t          rows[13];
    slot_t         slots[$];
    ev_t           exp_q[$];
    int            exp_g[$];
    int            ls, rs, nv, ne;
    int            lat_rise;

    initial begin : main
        rows[0]  = '{32, 32, 24'h123456, 24'hABCDEF, 0, 1, 0, 24'h123456, 24'hABCDEF};
        rows[1]  = '{32, 32, 24'h800000, 24'hFFFFFF, 1, 1, 0, 24'h800000, 24'hFFFFFF};
        rows[2]  = '{20, 32, 24'h111111, 24'h222222, 0, 0, 1, 24'h800000, 24'hFFFFFF};
        rows[3]  = '{32, 32, 24'h000001, 24'h000002, 0, 1, 0, 24'h000001, 24'h000002};
        rows[4]  = '{32, 40, 24'h0A0B0C, 24'h0D0E0F, 2, 1, 1, 24'h0A0B0C, 24'h0D0E0F};
        rows[5]  = '{32, 32, 24'h345678, 24'h9ABCDE, 2, 1, 0, 24'h345678, 24'h9ABCDE};
        rows[6]  = '{25, 25, 24'h7FFFFF, 24'h000000, 1, 1, 0, 24'h7FFFFF, 24'h000000};
        rows[7]  = '{24, 32, 24'h555555, 24'hAAAAAA, 1, 0, 1, 24'h7FFFFF, 24'h000000};
        rows[8]  = '{32, 32, 24'hC0FFEE, 24'hBADBEE, 0, 1, 0, 24'hC0FFEE, 24'hBADBEE};
        rows[9]  = '{33, 32, 24'h111111, 24'h222222, 0, 0, 1, 24'hC0FFEE, 24'hBADBEE};
        rows[10] = '{32, 20, 24'h0F0F0F, 24'hF0F0F0, 0, 0, 0, 24'hC0FFEE, 24'hBADBEE};
        rows[11] = '{32, 32, 24'h135790, 24'h246802, 2, 0, 1, 24'hC0FFEE, 24'hBADBEE};
        rows[12] = '{32, 32, 24'hABCDEF, 24'h123456, 0, 1, 0, 24'hABCDEF, 24'h123456};

        // ---------------- Reset with bclk toggling, lrclk low ----------------
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) bit_rise(1'b0, 1'($urandom_range(0, 1)));
        check("rst_audio_left", audio_left, 0);
        check("rst_audio_right", audio_right, 0);
        check("rst_pulses", obs_q.size(), 0);
        i2s_bclk = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("post_rst_pulses", obs_q.size(), 0);
        check("post_rst_left", audio_left, 0);

        // ---------------- Directed frame table ----------------
        g_drv = 0;
        drive_slot(1'b1, 32, 24'h0, 0, rs);  // preamble so lrclk is seen high
        for (int r = 0; r < 13; r++) begin
            obs_q.delete();
            drive_slot(1'b0, rows[r].llen, rows[r].lw, rows[r].pad, ls);
            drive_slot(1'b1, rows[r].rlen, rows[r].rw, rows[r].pad, rs);
            count_obs(nv, ne);
            $display("row %0d: valid=%0d err=%0d L=%06h R=%06h", r, nv, ne, audio_left, audio_right);
            check($sformatf("row%0d_valid_cnt", r), nv, rows[r].exp_valid);
            check($sformatf("row%0d_err_cnt", r), ne, rows[r].exp_err);
            check($sformatf("row%0d_left", r), audio_left, rows[r].exp_l);
            check($sformatf("row%0d_right", r), audio_right, rows[r].exp_r);
            if (r == 0) begin
                lat_rise = rs + DW;  // rise carrying the right slot's last data bit
                check("row0_latency", (obs_q.size() > 0) ? obs_q[0].cyc : -1,
                      rise_cyc[lat_rise] + 3);
            end
        end

        // ---------------- Ten consecutive frames ----------------
        obs_q.delete();
        for (int f = 0; f < 10; f++) begin
            drive_slot(1'b0, 32, 24'h800000, 1, ls);
            drive_slot(1'b1, 32, 24'hFFFFFF, 1, rs);
        end
        count_obs(nv, ne);
        check("ten_frames_valid", nv, 10);
        check("ten_frames_err", ne, 0);
        check("ten_frames_left", audio_left, 24'h800000);
        check("ten_frames_right", audio_right, 24'hFFFFFF);

        // ---------------- Reset in the middle of a right slot ----------------
        drive_slot(1'b0, 32, 24'h13579B, 0, ls);
        for (int i = 0; i < 10; i++) bit_rise(1'b1, 1'($urandom_range(0, 1)));
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_left", audio_left, 0);
        check("midrst_right", audio_right, 0);
        check("midrst_valid", sample_valid, 0);
        i2s_bclk = 1'b0;
        i2s_lrclk = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        g_drv = 0;
        obs_q.delete();
        drive_slot(1'b0, 32, 24'h11AA22, 0, ls);
        drive_slot(1'b1, 32, 24'h33BB44, 0, rs);
        drive_slot(1'b0, 32, 24'h55CC66, 0, ls);
        drive_slot(1'b1, 32, 24'h77DD88, 0, rs);
        count_obs(nv, ne);
        check("after_rst_valid", nv, 1);
        check("after_rst_err", ne, 0);
        check("after_rst_left", audio_left, 24'h55CC66);
        check("after_rst_right", audio_right, 24'h77DD88);

        // ---------------- Randomized slot stream vs slot-level model --------
        rst_n = 1'b0;
        i2s_bclk = 1'b0;
        i2s_lrclk = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        g_drv = 0;
        obs_q.delete();

        for (int k = 0; k < 60; k++) begin
            slot_t s;
            int    sel;
            s.lr = (k % 2 == 0) ? 1'b1 : 1'b0;
            sel  = $urandom_range(0, 9);
            if (sel == 0)      s.len = $urandom_range(2, DW);
            else if (sel == 1) s.len = $urandom_range(SW + 1, SW + 8);
            else if (sel == 2) s.len = DW + 1;
            else               s.len = $urandom_range(DW + 1, SW);
            s.w = DW'($urandom);
            slots.push_back(s);
        end

        // Slot-level model: a slot is "in sync" if it follows a well-formed
        // in-sync slot, or it is a left slot starting after the last error.
        begin
            int            g;
            bit            prev_sync;
            int            prev_len;
            int            resync_after;
            logic [DW-1:0] hold;
            ev_t           e;
            g = 0; prev_sync = 0; prev_len = 0; resync_after = -1; hold = '0;
            foreach (slots[k]) begin
                bit sync_now;
                int start;
                start = g;
                if (prev_sync) begin
                    if (prev_len - 1 < DW) begin
                        e.err = 1; e.l = '0; e.r = '0; e.cyc = 0;
                        exp_q.push_back(e); exp_g.push_back(start);
                        sync_now = 0;
                        resync_after = start;
                    end else begin
                        sync_now = 1;
                    end
                end else begin
                    sync_now = (slots[k].lr == 1'b0) && (k > 0) && (start > resync_after);
                end
                if (sync_now) begin
                    if (slots[k].len >= DW + 1) begin
                        if (slots[k].lr == 1'b0) begin
                            hold = slots[k].w;
                        end else begin
                            e.err = 0; e.l = hold; e.r = slots[k].w; e.cyc = 0;
                            exp_q.push_back(e); exp_g.push_back(start + DW);
                        end
                    end
                    if (slots[k].len > SW) begin
                        e.err = 1; e.l = '0; e.r = '0; e.cyc = 0;
                        exp_q.push_back(e); exp_g.push_back(start + SW);
                        sync_now = 0;
                        resync_after = start + SW;
                    end
                end
                prev_sync = sync_now;
                prev_len  = slots[k].len;
                g += slots[k].len;
            end
        end

        foreach (slots[k]) drive_slot(slots[k].lr, slots[k].len, slots[k].w, 2, ls);
        repeat (8) @(posedge clk);
        #2;

        foreach (exp_q[i]) exp_q[i].cyc = rise_cyc[exp_g[i]] + 3;

        check("rnd_event_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("rnd_ev%0d_kind", i), obs_q[i].err, exp_q[i].err);
            check($sformatf("rnd_ev%0d_cycle", i), obs_q[i].cyc, exp_q[i].cyc);
            if (!exp_q[i].err) begin
                check($sformatf("rnd_ev%0d_left", i), obs_q[i].l, exp_q[i].l);
                check($sformatf("rnd_ev%0d_right", i), obs_q[i].r, exp_q[i].r);
            end
        end

        check("pulse_rules", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_i2s_rx
